store_monitor: RTL and testbench

- Sits directly downstream of the processor `top` and sniffs its data-memory write bus (MemWrite, DataAdr, WriteData) every cycle.
- Buffers each observed store in a small show-ahead FIFO for a log/trace consumer.
- Counts run cycles and stores.
- Resolves a sticky pass/fail verdict from a signature store or a cycle timeout, replacing ad-hoc bench checks with synthesizable, reusable logic.

---
 rtl/store_monitor.sv | 153 +++++++++++++++
 tb/tb_store_monitor.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_monitor.sv
// Store monitor: sniffs the processor data-memory write bus, logs stores in a
// show-ahead FIFO, counts run cycles/stores and latches a pass/fail verdict.
module store_monitor #(
  parameter int unsigned DEPTH      = 8,
  parameter logic [31:0] PASS_ADDR  = 32'd100,
  parameter logic [31:0] PASS_DATA  = 32'd25,
  parameter int unsigned MAX_CYCLES = 200
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     MemWrite,
  input  logic [31:0]              DataAdr,
  input  logic [31:0]              WriteData,
  input  logic                     rd_en,
  output logic                     rd_valid,
  output logic [31:0]              rd_addr,
  output logic [31:0]              rd_data,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  output logic [15:0]              store_count,
  output logic [15:0]              cycle_count,
  output logic                     done,
  output logic                     pass,
  output logic                     fail
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
  localparam logic [15:0]   LAST_CYCLE = 16'(MAX_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    PASS = 2'd1,
    FAIL = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     cycle_q, cycle_d;
  logic [15:0]     store_q, store_d;
  logic            ovf_q, ovf_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [31:0]     mem_addr_q [DEPTH];
  logic [31:0]     mem_data_q [DEPTH];

  logic in_run;
  logic capture;
  logic sig_hit;
  logic fifo_empty;
  logic fifo_full;
  logic pop;
  logic push;
  logic drop;

  always_comb begin
    in_run     = (state_q == RUN);
    capture    = in_run && MemWrite;
    sig_hit    = capture && (DataAdr == PASS_ADDR);
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == FULL_CNT);
    pop        = rd_en && !fifo_empty;
    // A full FIFO still accepts a store when the consumer frees a slot this cycle.
    push       = capture && (!fifo_full || pop);
    drop       = capture && fifo_full && !pop;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == RUN) begin
      if (sig_hit) begin
        state_d = (WriteData == PASS_DATA) ? PASS : FAIL;
      end else if (cycle_q == LAST_CYCLE) begin
        state_d = FAIL;
      end
    end
  end

  always_comb begin
    cycle_d = cycle_q;
    store_d = store_q;
    ovf_d   = ovf_q;
    if (in_run) begin
      cycle_d = cycle_q + 16'd1;
    end
    if (capture && (store_q != 16'hFFFF)) begin
      store_d = store_q + 16'd1;
    end
    if (drop) begin
      ovf_d = 1'b1;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= RUN;
      cycle_q  <= '0;
      store_q  <= '0;
      ovf_q    <= 1'b0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      cycle_q  <= cycle_d;
      store_q  <= store_d;
      ovf_q    <= ovf_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: reads are masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr_q[wr_ptr_q] <= DataAdr;
      mem_data_q[wr_ptr_q] <= WriteData;
    end
  end

  always_comb begin
    rd_valid    = !fifo_empty;
    rd_addr     = fifo_empty ? 32'd0 : mem_addr_q[rd_ptr_q];
    rd_data     = fifo_empty ? 32'd0 : mem_data_q[rd_ptr_q];
    fifo_count  = count_q;
    overflow    = ovf_q;
    store_count = store_q;
    cycle_count = cycle_q;
    done        = (state_q != RUN);
    pass        = (state_q == PASS);
    fail        = (state_q == FAIL);
  end

endmodule

// File: tb/tb_store_monitor.sv
// Randomized and directed bench for store_monitor: a queue-based reference
// model predicts status each cycle; a monitor checks the FIFO head against a scoreboard.
module tb_store_monitor;

  localparam int DEPTH      = 8;
  localparam int MAX_CYCLES = 200;
  localparam logic [31:0] SIG_ADDR = 32'd100;
  localparam logic [31:0] SIG_PASS = 32'd25;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] DataAdr = '0;
  logic [31:0] WriteData = '0;
  logic        rd_en = 1'b0;
  logic        rd_valid;
  logic [31:0] rd_addr;
  logic [31:0] rd_data;
  logic [3:0]  fifo_count;
  logic        overflow;
  logic [15:0] store_count;
  logic [15:0] cycle_count;
  logic        done;
  logic        pass;
  logic        fail;

  store_monitor #(
    .DEPTH(DEPTH), .PASS_ADDR(SIG_ADDR), .PASS_DATA(SIG_PASS), .MAX_CYCLES(MAX_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
    .WriteData(WriteData), .rd_en(rd_en), .rd_valid(rd_valid), .rd_addr(rd_addr),
    .rd_data(rd_data), .fifo_count(fifo_count), .overflow(overflow),
    .store_count(store_count), .cycle_count(cycle_count), .done(done),
    .pass(pass), .fail(fail)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } entry_t;

  // Reference model: verdict 0=running, 1=pass, 2=fail.
  entry_t expQ[$];
  int     mVerdict;
  int     mCycles;
  int     mStores;
  int     mCount;
  bit     mOverflow;

  int nChecks = 0;
  int nPass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end else begin
      nPass++;
    end
  endtask

  task automatic modelReset();
    mVerdict  = 0;
    mCycles   = 0;
    mStores   = 0;
    mCount    = 0;
    mOverflow = 0;
    expQ.delete();
  endtask

  task automatic modelStep(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                           input bit ren);
    bit running;
    bit doPop;
    running = (mVerdict == 0);
    doPop   = ren && (mCount > 0);
    if (running) begin
      mCycles++;
      if (we) begin
        if (mStores < 65535) mStores++;
        if (mCount < DEPTH || doPop) begin
          expQ.push_back('{addr: adr, data: dat});
          mCount++;
        end else begin
          mOverflow = 1;
        end
        if (adr == SIG_ADDR) mVerdict = (dat == SIG_PASS) ? 1 : 2;
      end
      if (mVerdict == 0 && mCycles == MAX_CYCLES) mVerdict = 2;
    end
    if (doPop) mCount--;
  endtask

  task automatic checkOutput();
    check("done", done, 32'(mVerdict != 0));
    check("pass", pass, 32'(mVerdict == 1));
    check("fail", fail, 32'(mVerdict == 2));
    check("cycle_count", cycle_count, 32'(mCycles));
    check("store_count", store_count, 32'(mStores));
    check("fifo_count", fifo_count, 32'(mCount));
    check("overflow", overflow, 32'(mOverflow));
    check("rd_valid", rd_valid, 32'(mCount > 0));
    if (mCount == 0) begin
      check("empty_addr", rd_addr, 32'd0);
      check("empty_data", rd_data, 32'd0);
    end
  endtask

  // Called at posedge+1: drives one cycle of inputs, advances the model, checks after the edge.
  task automatic applyStimulus(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                               input bit ren);
    MemWrite  = we;
    DataAdr   = we ? adr : 32'hxxxx_xxxx;
    WriteData = we ? dat : 32'hxxxx_xxxx;
    rd_en     = ren;
    modelStep(we, adr, dat, ren);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic doReset();
    reset    = 1'b0;
    MemWrite = 1'b0;
    rd_en    = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 32'd0, 32'd0, 0);
  endtask

  // Scoreboard monitor: whenever the DUT presents a head entry it must match the oldest expected store.
  always @(negedge clk) begin
    if (reset && rd_valid) begin
      if (expQ.size() == 0) begin
        nChecks++;
        $display("[TB] FAIL sb_head actual=0x%0h/0x%0h expected=<no entry>", rd_addr, rd_data);
      end else begin
        check("head_addr", rd_addr, expQ[0].addr);
        check("head_data", rd_data, expQ[0].data);
        if (rd_en) void'(expQ.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    modelReset();
    #1;
    check("rst_rd_valid", rd_valid, 32'd0);
    check("rst_fifo_count", fifo_count, 32'd0);
    check("rst_done", done, 32'd0);
    doReset();

    // Idle run
    idle(5);
    check("t1_cycle5", cycle_count, 32'd5);
    check("t1_done", done, 32'd0);

    // Signature pass with logged stores, then drain
    doReset();
    applyStimulus(1, 32'h10, 32'hAA, 0);
    applyStimulus(1, 32'h14, 32'hBB, 0);
    applyStimulus(1, 32'd100, 32'd25, 0);
    check("t2_pass", pass, 32'd1);
    check("t2_done", done, 32'd1);
    check("t2_count", fifo_count, 32'd3);
    check("t2_stores", store_count, 32'd3);
    for (int i = 0; i < 3; i++) applyStimulus(0, 32'd0, 32'd0, 1);
    applyStimulus(1, 32'h20, 32'd1, 0);
    check("t2_ignored_count", fifo_count, 32'd0);
    check("t2_ignored_stores", store_count, 32'd3);

    // Signature fail
    doReset();
    applyStimulus(1, 32'd100, 32'd7, 0);
    check("t3_fail", fail, 32'd1);
    check("t3_pass", pass, 32'd0);
    check("t3_count", fifo_count, 32'd1);

    // Timeout, then signature on the timeout edge
    doReset();
    idle(MAX_CYCLES - 1);
    check("t4_not_yet", done, 32'd0);
    idle(1);
    check("t4_fail", fail, 32'd1);
    check("t4_cycles", cycle_count, 32'(MAX_CYCLES));
    idle(3);
    check("t4_hold", cycle_count, 32'(MAX_CYCLES));
    doReset();
    idle(MAX_CYCLES - 1);
    applyStimulus(1, 32'd100, 32'd25, 0);
    check("t4_sig_wins", pass, 32'd1);

    // Overflow and push-while-full-with-pop
    doReset();
    for (int i = 0; i < 10; i++) applyStimulus(1, 32'h200 + 32'(4 * i), 32'(i + 1), 0);
    check("t5_count", fifo_count, 32'd8);
    check("t5_ovf", overflow, 32'd1);
    check("t5_stores", store_count, 32'd10);
    check("t5_head", rd_addr, 32'h200);
    applyStimulus(1, 32'h300, 32'h55, 1);
    check("t5_full_pop", fifo_count, 32'd8);
    for (int i = 0; i < 9; i++) applyStimulus(0, 32'd0, 32'd0, 1);

    // Asynchronous reset mid-cycle
    doReset();
    for (int i = 0; i < 4; i++) applyStimulus(1, 32'h40 + 32'(i), 32'(i), 0);
    idle(33);
    check("t6_pre_cycles", cycle_count, 32'd37);
    #3;
    reset = 1'b0;
    #1;
    check("t6_rd_valid", rd_valid, 32'd0);
    check("t6_count", fifo_count, 32'd0);
    check("t6_cycles", cycle_count, 32'd0);
    check("t6_stores", store_count, 32'd0);
    check("t6_addr", rd_addr, 32'd0);
    modelReset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle(3);
    check("t6_restart", cycle_count, 32'd3);

    // Randomized runs
    for (int r = 0; r < 6; r++) begin
      int len;
      len = (r == 5) ? MAX_CYCLES + 20 : 80;
      doReset();
      for (int c = 0; c < len; c++) begin
        bit          we;
        bit          ren;
        logic [31:0] adr;
        logic [31:0] dat;
        we  = ($urandom_range(0, 99) < 60);
        ren = ($urandom_range(0, 2) == 0);
        adr = $urandom & 32'hFFFF_FFFC;
        if (adr == SIG_ADDR) adr = 32'd104;
        dat = $urandom;
        if (r != 5 && $urandom_range(0, 39) == 0) begin
          adr = SIG_ADDR;
          dat = $urandom_range(0, 1) ? SIG_PASS : dat;
        end
        applyStimulus(we, adr, dat, ren);
      end
      for (int c = 0; c < DEPTH + 1; c++) applyStimulus(0, 32'd0, 32'd0, 1);
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
